// File: rtl/l2_cache_wb.sv
// l2_cache_wb: set-associative write-back, write-allocate cache with
// round-robin replacement and a single outstanding access.
//
// Ports
//   clk, rst                   clock (rising edge), async active-high reset
//   req_valid/req_ready        upper request handshake (ready only when idle)
//   req_we, req_addr,
//   req_wdata, req_be          access type, byte address, write word, byte enables
//   resp_valid, resp_line      one-cycle completion pulse, line after the access
//   mem_req_valid/ready        lower request handshake
//   mem_req_we, mem_req_addr,
//   mem_req_wline              writeback (we=1) or fill request (we=0), line aligned
//   mem_resp_valid,
//   mem_resp_line              fill data, only consumed while waiting for a fill
//   hit_count, miss_count      saturating statistics
//
// state     | meaning
// ----------+-----------------------------------------------------------
// IDLE      | ready for a request
// LOOKUP    | tag compare; hit completes, miss picks a victim
// WRITEBACK | dirty victim line offered to memory
// FILL_REQ  | line read request offered to memory
// FILL_WAIT | waiting for fill data; install and merge the write
// RESPOND   | resp_valid pulse
module l2_cache_wb #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32,
  parameter int CACHE_SIZE = 16384,
  parameter int LINE_SIZE  = 16,
  parameter int WAYS       = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    req_valid,
  output logic                    req_ready,
  input  logic                    req_we,
  input  logic [ADDR_WIDTH-1:0]   req_addr,
  input  logic [DATA_WIDTH-1:0]   req_wdata,
  input  logic [DATA_WIDTH/8-1:0] req_be,
  output logic                    resp_valid,
  output logic [LINE_SIZE*8-1:0]  resp_line,
  output logic                    mem_req_valid,
  input  logic                    mem_req_ready,
  output logic                    mem_req_we,
  output logic [ADDR_WIDTH-1:0]   mem_req_addr,
  output logic [LINE_SIZE*8-1:0]  mem_req_wline,
  input  logic                    mem_resp_valid,
  input  logic [LINE_SIZE*8-1:0]  mem_resp_line,
  output logic [31:0]             hit_count,
  output logic [31:0]             miss_count
);

  localparam int LB        = LINE_SIZE * 8;
  localparam int BPW       = DATA_WIDTH / 8;
  localparam int WORDS     = LINE_SIZE / BPW;
  localparam int BYTE_BITS = $clog2(BPW);
  localparam int OFF_BITS  = $clog2(LINE_SIZE);
  localparam int WIDX_BITS = (OFF_BITS > BYTE_BITS) ? OFF_BITS - BYTE_BITS : 1;
  localparam int SETS      = CACHE_SIZE / LINE_SIZE / WAYS;
  localparam int SET_BITS  = $clog2(SETS);
  localparam int TAG_BITS  = ADDR_WIDTH - SET_BITS - OFF_BITS;
  localparam int WAY_BITS  = (WAYS > 1) ? $clog2(WAYS) : 1;

  typedef enum logic [2:0] {IDLE, LOOKUP, WRITEBACK, FILL_REQ, FILL_WAIT, RESPOND} state_t;
  state_t state;

  logic                  rq_we;
  logic [ADDR_WIDTH-1:0] rq_addr;
  logic [DATA_WIDTH-1:0] rq_wdata;
  logic [BPW-1:0]        rq_be;
  logic [WAY_BITS-1:0]   victim_q;

  logic [WAYS-1:0]     valid_q [SETS];
  logic [WAYS-1:0]     dirty_q [SETS];
  logic [WAY_BITS-1:0] rr_q    [SETS];
  logic [TAG_BITS-1:0] tag_mem [SETS][WAYS];
  logic [LB-1:0]       data_mem[SETS][WAYS];

  logic [SET_BITS-1:0]   rq_set;
  logic [TAG_BITS-1:0]   rq_tag;
  logic [WIDX_BITS-1:0]  rq_widx;
  logic [ADDR_WIDTH-1:0] fill_addr;
  logic                  unused_addr_bits;

  assign rq_set    = rq_addr[OFF_BITS +: SET_BITS];
  assign rq_tag    = rq_addr[ADDR_WIDTH-1 -: TAG_BITS];
  assign rq_widx   = rq_addr[BYTE_BITS +: WIDX_BITS];
  assign fill_addr = {rq_addr[ADDR_WIDTH-1:OFF_BITS], {OFF_BITS{1'b0}}};
  assign unused_addr_bits = ^rq_addr[BYTE_BITS-1:0];
  assign req_ready = (state == IDLE);

  function automatic logic [LB-1:0] merge_word(input logic [LB-1:0] line,
                                               input logic [WIDX_BITS-1:0] widx,
                                               input logic [DATA_WIDTH-1:0] wdata,
                                               input logic [BPW-1:0] be);
    logic [LB-1:0] res;
    res = line;
    for (int w = 0; w < WORDS; w++)
      for (int b = 0; b < BPW; b++)
        if (widx == WIDX_BITS'(w) && be[b])
          res[w*DATA_WIDTH + b*8 +: 8] = wdata[b*8 +: 8];
    return res;
  endfunction

  function automatic logic [WAY_BITS-1:0] next_way(input logic [WAY_BITS-1:0] w);
    return (w == WAY_BITS'(WAYS-1)) ? '0 : w + 1'b1;
  endfunction

  // Tag compare and victim choice; the descending scan leaves the lowest
  // invalid way, falling back to the round-robin pointer when the set is full.
  logic                hit;
  logic [WAY_BITS-1:0] hit_way;
  logic [WAY_BITS-1:0] victim;
  always_comb begin
    hit     = 1'b0;
    hit_way = '0;
    victim  = rr_q[rq_set];
    for (int w = 0; w < WAYS; w++)
      if (valid_q[rq_set][w] && tag_mem[rq_set][w] == rq_tag) begin
        hit     = 1'b1;
        hit_way = WAY_BITS'(w);
      end
    for (int w = WAYS - 1; w >= 0; w--)
      if (!valid_q[rq_set][w]) victim = WAY_BITS'(w);
  end

  // Line array write port: hit-write merge in LOOKUP, fill (+merge) in FILL_WAIT.
  logic                data_we;
  logic                tag_we;
  logic [WAY_BITS-1:0] wr_way;
  logic [LB-1:0]       wr_line;
  always_comb begin
    data_we = 1'b0;
    tag_we  = 1'b0;
    wr_way  = hit_way;
    wr_line = rq_we ? merge_word(data_mem[rq_set][hit_way], rq_widx, rq_wdata, rq_be)
                    : data_mem[rq_set][hit_way];
    if (state == LOOKUP && hit && rq_we) begin
      data_we = 1'b1;
    end else if (state == FILL_WAIT) begin
      wr_way  = victim_q;
      wr_line = rq_we ? merge_word(mem_resp_line, rq_widx, rq_wdata, rq_be) : mem_resp_line;
      data_we = mem_resp_valid;
      tag_we  = mem_resp_valid;
    end
  end

  always_ff @(posedge clk) begin
    if (data_we) data_mem[rq_set][wr_way] <= wr_line;
    if (tag_we)  tag_mem[rq_set][wr_way]  <= rq_tag;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= IDLE;
      rq_we         <= 1'b0;
      rq_addr       <= '0;
      rq_wdata      <= '0;
      rq_be         <= '0;
      victim_q      <= '0;
      resp_valid    <= 1'b0;
      resp_line     <= '0;
      mem_req_valid <= 1'b0;
      mem_req_we    <= 1'b0;
      mem_req_addr  <= '0;
      mem_req_wline <= '0;
      hit_count     <= '0;
      miss_count    <= '0;
      for (int s = 0; s < SETS; s++) begin
        valid_q[s] <= '0;
        dirty_q[s] <= '0;
        rr_q[s]    <= '0;
      end
    end else begin
      case (state)
        IDLE: if (req_valid) begin
          rq_we    <= req_we;
          rq_addr  <= req_addr;
          rq_wdata <= req_wdata;
          rq_be    <= req_be;
          state    <= LOOKUP;
        end
        LOOKUP: if (hit) begin
          // An all-zero byte enable writes nothing, so the line stays clean.
          if (rq_we && rq_be != '0) dirty_q[rq_set][hit_way] <= 1'b1;
          rr_q[rq_set] <= next_way(hit_way);
          if (hit_count != '1) hit_count <= hit_count + 32'd1;
          resp_line  <= wr_line;
          resp_valid <= 1'b1;
          state      <= RESPOND;
        end else begin
          victim_q <= victim;
          if (miss_count != '1) miss_count <= miss_count + 32'd1;
          mem_req_valid <= 1'b1;
          if (valid_q[rq_set][victim] && dirty_q[rq_set][victim]) begin
            mem_req_we    <= 1'b1;
            mem_req_addr  <= {tag_mem[rq_set][victim], rq_set, {OFF_BITS{1'b0}}};
            mem_req_wline <= data_mem[rq_set][victim];
            state         <= WRITEBACK;
          end else begin
            mem_req_we   <= 1'b0;
            mem_req_addr <= fill_addr;
            state        <= FILL_REQ;
          end
        end
        WRITEBACK: if (mem_req_ready) begin
          dirty_q[rq_set][victim_q] <= 1'b0;
          mem_req_we   <= 1'b0;
          mem_req_addr <= fill_addr;
          state        <= FILL_REQ;
        end
        FILL_REQ: if (mem_req_ready) begin
          mem_req_valid <= 1'b0;
          state         <= FILL_WAIT;
        end
        FILL_WAIT: if (mem_resp_valid) begin
          valid_q[rq_set][victim_q] <= 1'b1;
          dirty_q[rq_set][victim_q] <= rq_we;
          rr_q[rq_set] <= next_way(victim_q);
          resp_line    <= wr_line;
          resp_valid   <= 1'b1;
          state        <= RESPOND;
        end
        RESPOND: begin
          resp_valid <= 1'b0;
          state      <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_l2_cache_wb.sv
// tb_l2_cache_wb: directed test of l2_cache_wb with default parameters
// (256 sets x 4 ways, 16-byte lines). Memory side is driven by hand.
module tb_l2_cache_wb;
  localparam int LB = 128;

  localparam logic [LB-1:0] LA  = {4{32'hAAAAAAAA}};
  localparam logic [LB-1:0] L1  = {4{32'h11111111}};
  localparam logic [LB-1:0] L2  = {4{32'h22222222}};
  localparam logic [LB-1:0] L3  = {4{32'h33333333}};
  localparam logic [LB-1:0] L4  = {4{32'h44444444}};
  localparam logic [LB-1:0] L5  = {4{32'h55555555}};
  localparam logic [LB-1:0] L6  = {4{32'h66666666}};
  localparam logic [LB-1:0] L7  = {4{32'h77777777}};
  localparam logic [LB-1:0] L8  = {4{32'h88888888}};
  localparam logic [LB-1:0] LAW = {32'hAAAAAAAA, 32'hAAAAAAAA, 32'hAAAABEEF, 32'hAAAAAAAA};
  localparam logic [LB-1:0] LBW = {32'h00000000, 32'h00000000, 32'h0000BEEF, 32'h00000000};

  logic          clk = 1'b0;
  logic          rst;
  logic          req_valid, req_ready, req_we;
  logic [31:0]   req_addr, req_wdata;
  logic [3:0]    req_be;
  logic          resp_valid;
  logic [LB-1:0] resp_line;
  logic          mem_req_valid, mem_req_ready, mem_req_we;
  logic [31:0]   mem_req_addr;
  logic [LB-1:0] mem_req_wline;
  logic          mem_resp_valid;
  logic [LB-1:0] mem_resp_line;
  logic [31:0]   hit_count, miss_count;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  l2_cache_wb dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_be(req_be),
    .resp_valid(resp_valid), .resp_line(resp_line),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
    .mem_req_we(mem_req_we), .mem_req_addr(mem_req_addr), .mem_req_wline(mem_req_wline),
    .mem_resp_valid(mem_resp_valid), .mem_resp_line(mem_resp_line),
    .hit_count(hit_count), .miss_count(miss_count)
  );

  task automatic chk(input string tag, input logic [LB-1:0] obs, input logic [LB-1:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic we, input logic [31:0] addr, input logic [31:0] wd,
                      input logic [3:0] be);
    int n = 0;
    while (!req_ready && n < 50) begin tick(); n++; end
    chk("req_ready_wait", LB'(req_ready), LB'(1'b1));
    req_valid = 1'b1; req_we = we; req_addr = addr; req_wdata = wd; req_be = be;
    tick();
    req_valid = 1'b0;
  endtask

  task automatic mem_req(input string tag, input logic we, input logic [31:0] addr,
                         input logic [LB-1:0] wline);
    int n = 0;
    while (!mem_req_valid && n < 50) begin tick(); n++; end
    chk({tag, "_mreq_valid"}, LB'(mem_req_valid), LB'(1'b1));
    chk({tag, "_mreq_we"}, LB'(mem_req_we), LB'(we));
    chk({tag, "_mreq_addr"}, LB'(mem_req_addr), LB'(addr));
    if (we) chk({tag, "_mreq_wline"}, mem_req_wline, wline);
    mem_req_ready = 1'b1;
    tick();
    mem_req_ready = 1'b0;
  endtask

  task automatic fill(input logic [LB-1:0] line);
    mem_resp_valid = 1'b1;
    mem_resp_line  = line;
    tick();
    mem_resp_valid = 1'b0;
  endtask

  task automatic resp(input string tag, input logic [LB-1:0] line);
    int n = 0;
    while (!resp_valid && n < 50) begin tick(); n++; end
    chk({tag, "_resp_valid"}, LB'(resp_valid), LB'(1'b1));
    chk({tag, "_resp_line"}, resp_line, line);
    tick();
    chk({tag, "_resp_pulse"}, LB'(resp_valid), LB'(1'b0));
  endtask

  task automatic miss_read(input string tag, input logic [31:0] addr, input logic [LB-1:0] line);
    send(1'b0, addr, 32'h0, 4'h0);
    mem_req(tag, 1'b0, addr, '0);
    fill(line);
    resp(tag, line);
  endtask

  task automatic hit_acc(input string tag, input logic we, input logic [31:0] addr,
                         input logic [31:0] wd, input logic [3:0] be, input logic [LB-1:0] line);
    send(we, addr, wd, be);
    chk({tag, "_early"}, LB'(resp_valid), LB'(1'b0));
    tick();
    chk({tag, "_lat"}, LB'(resp_valid), LB'(1'b1));
    chk({tag, "_no_mreq"}, LB'(mem_req_valid), LB'(1'b0));
    resp(tag, line);
  endtask

  initial begin
    rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_wdata = '0; req_be = '0;
    mem_req_ready = 1'b0; mem_resp_valid = 1'b0; mem_resp_line = '0;
    #1;
    chk("rst_req_ready", LB'(req_ready), LB'(1'b1));
    chk("rst_resp_valid", LB'(resp_valid), LB'(1'b0));
    chk("rst_mreq_valid", LB'(mem_req_valid), LB'(1'b0));
    chk("rst_resp_line", resp_line, '0);
    chk("rst_hits", LB'(hit_count), LB'(32'd0));
    chk("rst_misses", LB'(miss_count), LB'(32'd0));
    repeat (2) @(posedge clk);
    @(negedge clk) rst = 1'b0;
    tick();

    // Cold miss, hit read, byte-enabled hit write, zero-enable hit write.
    miss_read("cold", 32'h0000_1000, LA);
    chk("cold_misses", LB'(miss_count), LB'(32'd1));
    hit_acc("hit_rd", 1'b0, 32'h0000_1000, 32'h0, 4'h0, LA);
    chk("hit_rd_hits", LB'(hit_count), LB'(32'd1));
    hit_acc("hit_wr", 1'b1, 32'h0000_1004, 32'hDEADBEEF, 4'b0011, LAW);
    hit_acc("hit_be0", 1'b1, 32'h0000_1008, 32'h12345678, 4'b0000, LAW);
    chk("hit_hits", LB'(hit_count), LB'(32'd3));

    // Stray fill data while idle must do nothing.
    mem_resp_valid = 1'b1; mem_resp_line = L8;
    tick();
    mem_resp_valid = 1'b0;
    chk("stray_resp", LB'(resp_valid), LB'(1'b0));
    tick();
    chk("stray_resp2", LB'(resp_valid), LB'(1'b0));
    chk("stray_ready", LB'(req_ready), LB'(1'b1));

    // Reset while waiting for a fill: transaction and dirty line are dropped.
    send(1'b0, 32'h0000_2000, 32'h0, 4'h0);
    mem_req("rst_fill", 1'b0, 32'h0000_2000, '0);
    #2 rst = 1'b1;
    #1;
    chk("midrst_resp_valid", LB'(resp_valid), LB'(1'b0));
    chk("midrst_mreq_valid", LB'(mem_req_valid), LB'(1'b0));
    chk("midrst_resp_line", resp_line, '0);
    chk("midrst_misses", LB'(miss_count), LB'(32'd0));
    chk("midrst_hits", LB'(hit_count), LB'(32'd0));
    chk("midrst_ready", LB'(req_ready), LB'(1'b1));
    @(negedge clk) rst = 1'b0;
    mem_resp_valid = 1'b1; mem_resp_line = L8;
    tick();
    mem_resp_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk("postrst_no_resp", LB'(resp_valid), LB'(1'b0));
      tick();
    end
    chk("postrst_ready", LB'(req_ready), LB'(1'b1));

    // Write miss into an invalidated set: plain fill (no writeback), merged word.
    send(1'b1, 32'h0000_1004, 32'hDEADBEEF, 4'b0011);
    mem_req("wr_miss", 1'b0, 32'h0000_1000, '0);
    fill('0);
    resp("wr_miss", LBW);
    chk("wr_miss_misses", LB'(miss_count), LB'(32'd1));

    // Fill the rest of set 0, then force eviction of the dirty 0x1000 line.
    miss_read("fill_t0", 32'h0000_0000, L1);
    miss_read("fill_t2", 32'h0000_2000, L2);
    miss_read("fill_t3", 32'h0000_3000, L3);
    send(1'b0, 32'h0000_4000, 32'h0, 4'h0);
    tick();
    for (int i = 0; i < 5; i++) begin
      chk("wb_hold_valid", LB'(mem_req_valid), LB'(1'b1));
      chk("wb_hold_we", LB'(mem_req_we), LB'(1'b1));
      chk("wb_hold_addr", LB'(mem_req_addr), LB'(32'h0000_1000));
      chk("wb_hold_wline", mem_req_wline, LBW);
      chk("wb_hold_no_resp", LB'(resp_valid), LB'(1'b0));
      tick();
    end
    mem_req("wb", 1'b1, 32'h0000_1000, LBW);
    mem_req("wb_fill", 1'b0, 32'h0000_4000, '0);
    fill(L4);
    resp("evict", L4);
    chk("evict_misses", LB'(miss_count), LB'(32'd5));

    // Round-robin order after misses and hits; a zero-enable write leaves 0x2000 clean.
    miss_read("rr_1000", 32'h0000_1000, L5);
    hit_acc("hit_be0_2000", 1'b1, 32'h0000_2008, 32'hFFFFFFFF, 4'b0000, L2);
    miss_read("rr_0000", 32'h0000_0000, L6);
    hit_acc("hit_4000", 1'b0, 32'h0000_4000, 32'h0, 4'h0, L4);
    miss_read("rr_3000", 32'h0000_3000, L7);
    miss_read("clean_5000", 32'h0000_5000, L8);
    chk("final_misses", LB'(miss_count), LB'(32'd9));
    chk("final_hits", LB'(hit_count), LB'(32'd2));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
